// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the MIPS MEM-stage data-memory port.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam logic [31:0] MIPS_DATA_BASE = 32'h1001_0000;
  localparam int unsigned CNT_W          = 4;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram_sp.sv
// Single-port synchronous RAM; registered read port clears on reset, array does not.
module data_ram_sp
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned ADDR_W       = (clog2(MEMORY_DEPTH) == 0) ? 1 : clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register doubles as the port's load-data output, so it holds between loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_port.sv
// MEM-stage data-memory responder: range-checks the ALU word index, performs the
// access after WAIT_STATES cycles and stalls the pipeline through busy_o meanwhile.
module data_mem_port
  import mips_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned WAIT_STATES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [31:0]           word_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic                  read_valid_o,
  output logic                  write_ack_o,
  output logic                  addr_error_o,
  output logic                  busy_o
);

  localparam int unsigned ADDR_W = (clog2(MEMORY_DEPTH) == 0) ? 1 : clog2(MEMORY_DEPTH);
  // ACCESS spans WAIT_STATES cycles; the last one (counter==0) issues the RAM op.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES == 0) ? CNT_W'(0) : CNT_W'(WAIT_STATES - 1);

  mem_state_t            r_state;
  mem_state_t            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_is_write;
  logic                  r_read_valid;
  logic                  r_write_ack;
  logic                  r_addr_error;

  logic                  w_in_range;
  logic                  w_one_op;
  logic                  w_req;
  logic                  w_accept;
  logic                  w_reject;
  logic                  w_busy;
  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [ADDR_W-1:0]     w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_wdata;

  // An underflowed (A+B)-base wraps to a huge unsigned index and fails this check.
  assign w_in_range = (word_index_i < 32'(MEMORY_DEPTH));
  assign w_one_op   = mem_read_i ^ mem_write_i;
  assign w_req      = mem_read_i | mem_write_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_ram_en    = 1'b0;
    w_ram_we    = r_is_write;
    w_ram_addr  = r_addr;
    w_ram_wdata = r_wdata;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_one_op && w_in_range) begin
            w_accept = 1'b1;
            w_busy   = 1'b1;
            if (WAIT_STATES == 0) begin
              w_ram_en    = 1'b1;
              w_ram_we    = mem_write_i;
              w_ram_addr  = word_index_i[ADDR_W-1:0];
              w_ram_wdata = write_data_i;
              w_next      = DONE;
            end else begin
              w_next = ACCESS;
            end
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ACCESS: begin
        w_busy = 1'b1;
        if (r_cnt == '0) begin
          w_ram_en = 1'b1;
          w_next   = DONE;
        end
      end
      DONE: begin
        // Inputs still show the retiring request here; ignore them.
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (reset) begin
      w_busy   = 1'b0;
      w_ram_en = 1'b0;
      w_reject = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_is_write   <= 1'b0;
      r_read_valid <= 1'b0;
      r_write_ack  <= 1'b0;
      r_addr_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt      <= CNT_LOAD;
        r_addr     <= word_index_i[ADDR_W-1:0];
        r_wdata    <= write_data_i;
        r_is_write <= mem_write_i;
      end else if ((r_state == ACCESS) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      r_read_valid <= w_ram_en && !w_ram_we;
      r_write_ack  <= w_ram_en && w_ram_we;
      r_addr_error <= w_reject;
    end
  end

  data_ram_sp #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_ram_en),
    .i_we   (w_ram_we),
    .i_addr (w_ram_addr),
    .i_wdata(w_ram_wdata),
    .o_rdata(read_data_o)
  );

  assign read_valid_o = r_read_valid;
  assign write_ack_o  = r_write_ack;
  assign addr_error_o = r_addr_error;
  assign busy_o       = w_busy;

endmodule
